// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
// Control bundle between the multicycle sequencer and the datapath.
// master: the controller (drives selects and enables).
// slave:  the datapath (drives opcode, zero flag and memory ready).
interface multicycle_controller_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       illegal_op;

    modport master (
        input  op, zero, mem_ready,
        output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
               AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
               AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_op
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore sequencer for the multicycle RISC-V core: FETCH, DECODE, then the
// execute / memory / writeback states of each instruction class. Stalls in
// FETCH, MEMREAD and MEMWRITE until mem_ready.
// Optional feature macro: MC_JAL_EN (defined = jal supported via JAL state;
// undefined = jal opcode decodes as illegal).
module multicycle_controller (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_controller_if.master        ctrl
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
`ifdef MC_JAL_EN
    localparam logic [3:0] JAL      = 4'd10;
`endif

    logic [3:0] state;
    logic [3:0] next_state;
    logic       pc_update;
    logic       branch;
    logic       decode_illegal;

    // State register; synchronous reset returns to FETCH.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; combinational blocks below use blocking (=).
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, including the illegal-opcode detection in DECODE.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        next_state     = FETCH;
        decode_illegal = 1'b0;
        case (state)
            FETCH:    next_state = ctrl.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (ctrl.op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECR;
                    OP_I:         next_state = EXECI;
                    OP_BEQ:       next_state = BEQ;
`ifdef MC_JAL_EN
                    OP_JAL:       next_state = JAL;
`endif
                    default: begin
                        next_state     = FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (ctrl.op == OP_LW) begin
                    next_state = MEMREAD;
                end else if (ctrl.op == OP_SW) begin
                    next_state = MEMWRITE;
                end else begin
                    next_state = FETCH;
                end
            end
            MEMREAD:  next_state = ctrl.mem_ready ? MEMWB : MEMREAD;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = ctrl.mem_ready ? FETCH : MEMWRITE;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = FETCH;
`ifdef MC_JAL_EN
            JAL:      next_state = ALUWB;
`endif
            default:  next_state = FETCH;
        endcase
    end

    // Moore outputs per state, mem_ready gating, and reset override.
    always_comb begin
        ctrl.ALUOp      = 2'b00;
        ctrl.ALUSrcA    = 2'b00;
        ctrl.ALUSrcB    = 2'b00;
        ctrl.ResultSrc  = 2'b00;
        ctrl.AdrSrc     = 1'b0;
        ctrl.IRWrite    = 1'b0;
        ctrl.RegWrite   = 1'b0;
        ctrl.MemWrite   = 1'b0;
        ctrl.illegal_op = 1'b0;
        pc_update       = 1'b0;
        branch          = 1'b0;
        case (state)
            FETCH: begin
                ctrl.ALUSrcB   = 2'b10;
                ctrl.ResultSrc = 2'b10;
                ctrl.IRWrite   = ctrl.mem_ready;
                pc_update      = ctrl.mem_ready;
            end
            DECODE: begin
                ctrl.ALUSrcA    = 2'b01;
                ctrl.ALUSrcB    = 2'b01;
                ctrl.illegal_op = decode_illegal;
            end
            MEMADR: begin
                ctrl.ALUSrcA = 2'b10;
                ctrl.ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                ctrl.AdrSrc = 1'b1;
            end
            MEMWB: begin
                ctrl.ResultSrc = 2'b01;
                ctrl.RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                ctrl.AdrSrc   = 1'b1;
                ctrl.MemWrite = ctrl.mem_ready;
            end
            EXECR: begin
                ctrl.ALUSrcA = 2'b10;
                ctrl.ALUOp   = 2'b10;
            end
            EXECI: begin
                ctrl.ALUSrcA = 2'b10;
                ctrl.ALUSrcB = 2'b01;
                ctrl.ALUOp   = 2'b10;
            end
            ALUWB: begin
                ctrl.RegWrite = 1'b1;
            end
            BEQ: begin
                ctrl.ALUSrcA = 2'b10;
                ctrl.ALUOp   = 2'b01;
                branch       = 1'b1;
            end
`ifdef MC_JAL_EN
            JAL: begin
                ctrl.ALUSrcA = 2'b01;
                ctrl.ALUSrcB = 2'b10;
                pc_update    = 1'b1;
            end
`endif
            default: ;
        endcase

        // While reset is high, all enables drop and selects show FETCH values.
        if (reset) begin
            ctrl.ALUOp      = 2'b00;
            ctrl.ALUSrcA    = 2'b00;
            ctrl.ALUSrcB    = 2'b10;
            ctrl.ResultSrc  = 2'b10;
            ctrl.AdrSrc     = 1'b0;
            ctrl.IRWrite    = 1'b0;
            ctrl.RegWrite   = 1'b0;
            ctrl.MemWrite   = 1'b0;
            ctrl.illegal_op = 1'b0;
            pc_update       = 1'b0;
            branch          = 1'b0;
        end
    end

    assign ctrl.PCWrite = pc_update | (branch & ctrl.zero);

    // Immediate format select, decoded straight from the opcode.
    always_comb begin
        ctrl.ImmSrc = 2'b00;
        if (!reset) begin
            case (ctrl.op)
                OP_SW:   ctrl.ImmSrc = 2'b01;
                OP_BEQ:  ctrl.ImmSrc = 2'b10;
`ifdef MC_JAL_EN
                OP_JAL:  ctrl.ImmSrc = 2'b11;
`endif
                default: ctrl.ImmSrc = 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Per-cycle scoreboard: each stimulus cycle pushes the expected control
// vector, which is popped and compared at the following falling edge.
// Honors MC_JAL_EN the same way as the design.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [15:0] sb[$];

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector: {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
    //          AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_op}
    function automatic logic [15:0] mk(
        input logic [1:0] aluop, input logic [1:0] srca, input logic [1:0] srcb,
        input logic [1:0] res, input logic [1:0] imm, input logic adr,
        input logic ir, input logic pcw, input logic rw, input logic mw,
        input logic ill);
        return {aluop, srca, srcb, res, imm, adr, ir, pcw, rw, mw, ill};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == OP_SW)  return 2'b01;
        if (op == OP_BEQ) return 2'b10;
`ifdef MC_JAL_EN
        if (op == OP_JAL) return 2'b11;
`endif
        return 2'b00;
    endfunction

    function automatic logic [15:0] e_rst();
        return mk(2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_fetch(input logic [6:0] op, input logic mr);
        return mk(2'b00, 2'b00, 2'b10, 2'b10, imm_of(op), 0, mr, mr, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_dec(input logic [6:0] op, input logic ill);
        return mk(2'b00, 2'b01, 2'b01, 2'b00, imm_of(op), 0, 0, 0, 0, 0, ill);
    endfunction
    function automatic logic [15:0] e_memadr(input logic [6:0] op);
        return mk(2'b00, 2'b10, 2'b01, 2'b00, imm_of(op), 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_memread(input logic [6:0] op);
        return mk(2'b00, 2'b00, 2'b00, 2'b00, imm_of(op), 1, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_memwb(input logic [6:0] op);
        return mk(2'b00, 2'b00, 2'b00, 2'b01, imm_of(op), 0, 0, 0, 1, 0, 0);
    endfunction
    function automatic logic [15:0] e_memwrite(input logic [6:0] op, input logic mr);
        return mk(2'b00, 2'b00, 2'b00, 2'b00, imm_of(op), 1, 0, 0, 0, mr, 0);
    endfunction
    function automatic logic [15:0] e_execr(input logic [6:0] op);
        return mk(2'b10, 2'b10, 2'b00, 2'b00, imm_of(op), 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_execi(input logic [6:0] op);
        return mk(2'b10, 2'b10, 2'b01, 2'b00, imm_of(op), 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_aluwb(input logic [6:0] op);
        return mk(2'b00, 2'b00, 2'b00, 2'b00, imm_of(op), 0, 0, 0, 1, 0, 0);
    endfunction
    function automatic logic [15:0] e_beq(input logic z);
        return mk(2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 0, 0, z, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_jal(input logic [6:0] op);
        return mk(2'b00, 2'b01, 2'b10, 2'b00, imm_of(op), 0, 0, 1, 0, 0, 0);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, push expectation, compare mid-cycle.
    task automatic step(input string tag, input logic rst, input logic [6:0] op,
                        input logic z, input logic mr, input logic [15:0] exp);
        logic [15:0] obs;
        reset         = rst;
        bus.op        = op;
        bus.zero      = z;
        bus.mem_ready = mr;
        sb.push_back(exp);
        @(negedge clk);
        obs = {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc,
               bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite,
               bus.illegal_op};
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check(tag, obs, sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.op        = OP_R;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        #1;

        // Reset held 2 cycles with live inputs: enables stay off.
        step("rst0", 1, OP_R, 1, 1, e_rst());
        step("rst1", 1, OP_R, 1, 1, e_rst());

        // R-type: 4 cycles.
        step("r_fetch", 0, OP_R, 0, 1, e_fetch(OP_R, 1));
        step("r_dec",   0, OP_R, 0, 1, e_dec(OP_R, 0));
        step("r_exec",  0, OP_R, 0, 1, e_execr(OP_R));
        step("r_wb",    0, OP_R, 0, 1, e_aluwb(OP_R));

        // lw with 2 stall cycles in MEMREAD: 7 cycles.
        step("lw_fetch", 0, OP_LW, 0, 1, e_fetch(OP_LW, 1));
        step("lw_dec",   0, OP_LW, 0, 1, e_dec(OP_LW, 0));
        step("lw_adr",   0, OP_LW, 0, 0, e_memadr(OP_LW));
        step("lw_rd0",   0, OP_LW, 0, 0, e_memread(OP_LW));
        step("lw_rd1",   0, OP_LW, 0, 0, e_memread(OP_LW));
        step("lw_rd2",   0, OP_LW, 0, 1, e_memread(OP_LW));
        step("lw_wb",    0, OP_LW, 0, 1, e_memwb(OP_LW));

        // sw with 3 stall cycles in FETCH.
        for (int i = 0; i < 3; i++)
            step($sformatf("sw_fstall%0d", i), 0, OP_SW, 0, 0, e_fetch(OP_SW, 0));
        step("sw_fetch", 0, OP_SW, 0, 1, e_fetch(OP_SW, 1));
        step("sw_dec",   0, OP_SW, 0, 1, e_dec(OP_SW, 0));
        step("sw_adr",   0, OP_SW, 0, 1, e_memadr(OP_SW));
        step("sw_wr",    0, OP_SW, 0, 1, e_memwrite(OP_SW, 1));

        // sw with one stall cycle in MEMWRITE: MemWrite only when ready.
        step("sw2_fetch", 0, OP_SW, 0, 1, e_fetch(OP_SW, 1));
        step("sw2_dec",   0, OP_SW, 0, 1, e_dec(OP_SW, 0));
        step("sw2_adr",   0, OP_SW, 0, 1, e_memadr(OP_SW));
        step("sw2_wr0",   0, OP_SW, 0, 0, e_memwrite(OP_SW, 0));
        step("sw2_wr1",   0, OP_SW, 0, 1, e_memwrite(OP_SW, 1));

        // beq taken; mem_ready low in DECODE/BEQ must be ignored.
        step("beq1_fetch", 0, OP_BEQ, 0, 1, e_fetch(OP_BEQ, 1));
        step("beq1_dec",   0, OP_BEQ, 1, 0, e_dec(OP_BEQ, 0));
        step("beq1_ex",    0, OP_BEQ, 1, 0, e_beq(1));
        // beq not taken.
        step("beq0_fetch", 0, OP_BEQ, 1, 1, e_fetch(OP_BEQ, 1));
        step("beq0_dec",   0, OP_BEQ, 0, 1, e_dec(OP_BEQ, 0));
        step("beq0_ex",    0, OP_BEQ, 0, 1, e_beq(0));

        // I-type ALU: 4 cycles.
        step("i_fetch", 0, OP_I, 0, 1, e_fetch(OP_I, 1));
        step("i_dec",   0, OP_I, 0, 1, e_dec(OP_I, 0));
        step("i_exec",  0, OP_I, 0, 1, e_execi(OP_I));
        step("i_wb",    0, OP_I, 0, 1, e_aluwb(OP_I));

        // Unsupported opcode: 2 cycles, illegal_op pulse in DECODE.
        step("bad_fetch", 0, OP_BAD, 0, 1, e_fetch(OP_BAD, 1));
        step("bad_dec",   0, OP_BAD, 0, 1, e_dec(OP_BAD, 1));

        // jal: executes when enabled, otherwise illegal.
        step("jal_fetch", 0, OP_JAL, 0, 1, e_fetch(OP_JAL, 1));
`ifdef MC_JAL_EN
        step("jal_dec",   0, OP_JAL, 0, 1, e_dec(OP_JAL, 0));
        step("jal_ex",    0, OP_JAL, 0, 1, e_jal(OP_JAL));
        step("jal_wb",    0, OP_JAL, 0, 1, e_aluwb(OP_JAL));
`else
        step("jal_dec",   0, OP_JAL, 0, 1, e_dec(OP_JAL, 1));
`endif

        // Reset during MEMWB: no writeback, then FETCH.
        step("rwb_fetch", 0, OP_LW, 0, 1, e_fetch(OP_LW, 1));
        step("rwb_dec",   0, OP_LW, 0, 1, e_dec(OP_LW, 0));
        step("rwb_adr",   0, OP_LW, 0, 1, e_memadr(OP_LW));
        step("rwb_rd",    0, OP_LW, 0, 1, e_memread(OP_LW));
        step("rwb_rst",   1, OP_LW, 0, 1, e_rst());
        step("rwb_fetch2", 0, OP_R, 0, 1, e_fetch(OP_R, 1));
        step("rwb_dec2",   0, OP_R, 0, 1, e_dec(OP_R, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

endmodule
